// File: rtl/post_norm_addsub27.sv
//==============================================================================
// Module  : post_norm_addsub27
// Brief   : Iterative one-bit-per-clock post-normaliser for the 27-bit FPU
//           mantissa add/sub result, with valid/ready handshakes.
// Revision: 1.0
//==============================================================================
`default_nettype none

module post_norm_addsub27 #(
    parameter int FRAC_W = 27,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              co,
    input  logic [FRAC_W-1:0] sum,
    input  logic [EXP_W-1:0]  exp_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FRAC_W-1:0] frac_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              zero_out,
    output logic              ovf_out
);

    localparam int                CNT_W    = $clog2(FRAC_W);
    localparam logic [EXP_W:0]    EXP_ONE  = (EXP_W+1)'(1);
    localparam logic [EXP_W:0]    EXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAC_W-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [FRAC_W-1:0]   frac_q, frac_d;
    logic [EXP_W:0]      exp_q, exp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;

    logic [EXP_W:0]      w_e;
    logic [EXP_W:0]      w_e_inc;
    logic [EXP_W:0]      w_exp_dec;
    logic [FRAC_W-1:0]   w_frac_sh;
    logic [CNT_W-1:0]    w_cnt_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            frac_q  <= '0;
            exp_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frac_q  <= frac_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        // A zero input exponent is the denormal encoding and behaves as 1.
        w_e       = (exp_in == '0) ? EXP_ONE : {1'b0, exp_in};
        w_e_inc   = w_e + EXP_ONE;
        w_exp_dec = exp_q - EXP_ONE;
        w_frac_sh = {frac_q[FRAC_W-2:0], 1'b0};
        w_cnt_inc = cnt_q + CNT_W'(1);

        state_d = state_q;
        frac_d  = frac_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    zero_d  = 1'b0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                    if (co) begin
                        if (w_e_inc >= EXP_MAX) begin
                            exp_d  = EXP_MAX;
                            frac_d = '0;
                            ovf_d  = 1'b1;
                        end else begin
                            frac_d = {1'b1, sum[FRAC_W-1:2], sum[1] | sum[0]};
                            exp_d  = w_e_inc;
                        end
                    end else if (sum == '0) begin
                        frac_d = '0;
                        exp_d  = '0;
                        zero_d = 1'b1;
                    end else if (sum[FRAC_W-1]) begin
                        frac_d = sum;
                        exp_d  = w_e;
                    end else if (w_e == EXP_ONE) begin
                        frac_d = sum;
                        exp_d  = '0;
                    end else begin
                        frac_d  = sum;
                        exp_d   = w_e;
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                frac_d = w_frac_sh;
                exp_d  = w_exp_dec;
                cnt_d  = w_cnt_inc;
                if (w_frac_sh[FRAC_W-1] || (w_exp_dec == EXP_ONE) || (w_cnt_inc == CNT_LAST)) begin
                    state_d = S_DONE;
                end
                // Ran out of exponent before reaching the hidden bit: denormal.
                if (!w_frac_sh[FRAC_W-1] && (w_exp_dec == EXP_ONE)) begin
                    exp_d = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign frac_out  = frac_q;
    assign exp_out   = exp_q[EXP_W-1:0];
    assign zero_out  = zero_q;
    assign ovf_out   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_post_norm_addsub27.sv
//==============================================================================
// Module  : tb_post_norm_addsub27
// Brief   : Self-checking bench for post_norm_addsub27 with a normalisation model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_post_norm_addsub27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        co = 1'b0;
    logic [26:0] sum = '0;
    logic [7:0]  exp_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [26:0] frac_out;
    logic [7:0]  exp_out;
    logic        zero_out;
    logic        ovf_out;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    post_norm_addsub27 #(.FRAC_W(27), .EXP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .co        (co),
        .sum       (sum),
        .exp_in    (exp_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frac_out  (frac_out),
        .exp_out   (exp_out),
        .zero_out  (zero_out),
        .ovf_out   (ovf_out)
    );

    always #5 clk = ~clk;

    // Reference: count leading zeros, shift as far as the exponent allows.
    function automatic void model(input bit c, input int unsigned s, input int unsigned ei,
                                  output int unsigned f, output int unsigned eo,
                                  output bit z, output bit o, output int k);
        int unsigned e;
        int lz;
        e = (ei == 0) ? 1 : ei;
        k = 0; z = 0; o = 0; f = 0; eo = 0;
        if (c) begin
            if (e + 1 >= 255) begin
                eo = 255; o = 1;
            end else begin
                f  = ((s | (32'd1 << 27)) >> 1) | (s & 1);
                eo = e + 1;
            end
        end else if (s == 0) begin
            z = 1;
        end else begin
            lz = 0;
            while (((s >> (26 - lz)) & 1) == 0) lz++;
            k  = (lz < int'(e) - 1) ? lz : int'(e) - 1;
            f  = (s << k) & 32'h07FF_FFFF;
            eo = ((f >> 26) & 1) ? e - k : 0;
        end
    endfunction

    task automatic run_op(input bit c, input logic [26:0] s, input logic [7:0] e,
                          output int lat, output logic [26:0] f, output logic [7:0] eo,
                          output logic z, output logic o);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        co = c; sum = s; exp_in = e; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        f = frac_out; eo = exp_out; z = zero_out; o = ovf_out;
        if (out_ready) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({out_valid, frac_out, exp_out, zero_out, ovf_out} !== '0)
            $display("FAIL reset_outputs: got v=%b f=%h e=%h z=%b o=%b, want all 0",
                     out_valid, frac_out, exp_out, zero_out, ovf_out);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [26:0] sv [5] = '{27'h0000003, 27'h0800000, 27'h0000000, 27'h0000100, 27'h7FFFFFF};
        logic [7:0]  ev [5] = '{8'h80, 8'h80, 8'h55, 8'h03, 8'hFE};
        bit          cv [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [26:0] fx [5] = '{27'h4000001, 27'h4000000, 27'h0, 27'h0000400, 27'h0};
        logic [7:0]  ex [5] = '{8'h81, 8'h7D, 8'h00, 8'h00, 8'hFF};
        int          lx [5] = '{0, 3, 0, 2, 0};
        bit          zx [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bit          ox [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat; logic [26:0] f; logic [7:0] eo; logic z, o;
        for (int i = 0; i < 5; i++) begin
            run_op(cv[i], sv[i], ev[i], lat, f, eo, z, o);
            chk_cnt++;
            if (f !== fx[i]) $display("FAIL dir%0d_frac: got %h want %h", i+1, f, fx[i]);
            else pass_cnt++;
            chk_cnt++;
            if (eo !== ex[i]) $display("FAIL dir%0d_exp: got %h want %h", i+1, eo, ex[i]);
            else pass_cnt++;
            chk_cnt++;
            if (lat !== lx[i]) $display("FAIL dir%0d_latency: got %0d want %0d", i+1, lat, lx[i]);
            else pass_cnt++;
            chk_cnt++;
            if ({z, o} !== {zx[i], ox[i]})
                $display("FAIL dir%0d_flags: got z=%b o=%b want z=%b o=%b", i+1, z, o, zx[i], ox[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat, k; logic [26:0] f, s; logic [7:0] eo, e; logic z, o;
        int unsigned mf, me; bit mz, mo; bit c;
        for (int i = 0; i < 200; i++) begin
            c = ($urandom_range(0, 3) == 0);
            s = 27'(($urandom & 32'h07FF_FFFF) >> $urandom_range(0, 27));
            case ($urandom_range(0, 7))
                0: e = 8'h00;
                1: e = 8'h01;
                2: e = 8'h02;
                3: e = 8'hFE;
                4: e = 8'hFF;
                default: e = 8'($urandom);
            endcase
            model(c, 32'(s), 32'(e), mf, me, mz, mo, k);
            run_op(c, s, e, lat, f, eo, z, o);
            chk_cnt++;
            if (f !== mf[26:0] || eo !== me[7:0] || z !== mz || o !== mo || lat !== k)
                $display("FAIL rand%0d: in co=%b sum=%h exp=%h got f=%h e=%h z=%b o=%b lat=%0d want f=%h e=%h z=%b o=%b lat=%0d",
                         i, c, s, e, f, eo, z, o, lat, mf[26:0], me[7:0], mz, mo, k);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_ignore();
        int lat; int unsigned mf, me; bit mz, mo; int k; bit rdy_bad;
        model(1'b0, 32'h1, 32'h80, mf, me, mz, mo, k);
        co = 1'b0; sum = 27'h0000001; exp_in = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        co = 1'b1; sum = 27'h5A5A5A5; exp_in = 8'h10;
        lat = 0; rdy_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready) rdy_bad = 1'b1;
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        chk_cnt++;
        if (rdy_bad) $display("FAIL busy_in_ready: got 1 while busy want 0");
        else pass_cnt++;
        chk_cnt++;
        if (frac_out !== mf[26:0] || exp_out !== me[7:0] || lat !== k)
            $display("FAIL busy_result: got f=%h e=%h lat=%0d want f=%h e=%h lat=%0d",
                     frac_out, exp_out, lat, mf[26:0], me[7:0], k);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure_reset();
        int lat; logic [26:0] f; logic [7:0] eo; logic z, o; bit bad;
        out_ready = 1'b0;
        run_op(1'b0, 27'h0800000, 8'h80, lat, f, eo, z, o);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || frac_out !== 27'h4000000 || exp_out !== 8'h7D) bad = 1'b1;
        end
        chk_cnt++;
        if (bad) $display("FAIL hold_stable: got v=%b rdy=%b f=%h e=%h want v=1 rdy=0 f=4000000 e=7d",
                          out_valid, in_ready, frac_out, exp_out);
        else pass_cnt++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL hold_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
        co = 1'b0; sum = 27'h0800000; exp_in = 8'h80; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL rst_mid_shift_valid: got %b want 0", out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL rst_mid_shift_ready: got %b want 1", in_ready);
        else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad = 1'b1;
        end
        chk_cnt++;
        if (bad) $display("FAIL rst_no_result: got out_valid 1 want 0");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_backpressure_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
